// File: rtl/img_stream_gen_pkg.sv
// Shared image-processing definitions: FSM state encoding, pixel-source
// encodings and the counter widths used by the stream generator.
package img_stream_gen_pkg;

  localparam int CNT_W   = 11;  // hcnt / vcnt width
  localparam int PHASE_W = 12;  // per-state phase counter width
  localparam int PIX_W   = 8;   // gray pixel width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VBACK  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VFRONT = 3'd4,
    ST_VSLOW  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PAT_EXT     = 2'd0,  // external source via src_rd_en / src_rd_data
    PAT_HRAMP   = 2'd1,
    PAT_VRAMP   = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  // 8x8 checkerboard cell: white when exactly one of the coordinates is
  // in an odd 8-pixel band.
  function automatic logic [PIX_W-1:0] checker_px(input logic h3, input logic v3);
    return (h3 ^ v3) ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/img_pattern_mux.sv
// Pixel source selector: external data or one of three synthetic patterns.
// Purely combinational; the caller decides when the result is registered.
module img_pattern_mux
  import img_stream_gen_pkg::*;
(
  input  logic [PIX_W-1:0] hcnt_i,       // low bits of the pixel counter
  input  logic [PIX_W-1:0] vcnt_i,       // low bits of the line counter
  input  pattern_e         pattern_i,
  input  logic [PIX_W-1:0] src_rd_data_i,
  output logic [PIX_W-1:0] gray_o
);

  // Select the gray value for the current pattern.
  always_comb begin
    gray_o = '0;
    unique case (pattern_i)
      PAT_EXT:     gray_o = src_rd_data_i;
      PAT_HRAMP:   gray_o = hcnt_i;
      PAT_VRAMP:   gray_o = vcnt_i;
      PAT_CHECKER: gray_o = checker_px(hcnt_i[3], vcnt_i[3]);
      default:     gray_o = '0;
    endcase
  end

endmodule

// File: rtl/img_stream_gen.sv
// Video-style frame generator: produces vsync/href/gray timing for a
// frame of IMG_V_DISP lines by IMG_H_DISP pixels, sourcing pixels from
// an external reader or an internal test pattern.
// V_FRONT must cover the downstream 3x3 window latency (DELAY_NUM +
// IMG_H_DISP + 2) so the last lines drain before vsync drops.
//
// Handshake: there is no valid/ready pair; src_rd_en is a strobe and the
// source must present src_rd_data exactly one cycle later, every time.
// out_img_gray is only meaningful while out_img_href is high.
module img_stream_gen
  import img_stream_gen_pkg::*;
#(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int H_BLANK    = 160,
  parameter int V_BACK     = 800,
  parameter int V_FRONT    = 800,
  parameter int V_SYNC_LOW = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  input  logic [1:0]       pattern_sel,
  output logic             src_rd_en,
  input  logic [PIX_W-1:0] src_rd_data,
  output logic             out_img_vsync,
  output logic             out_img_href,
  output logic [PIX_W-1:0] out_img_gray,
  output logic             busy,
  output logic             frame_done,
  output state_e           dbg_state
);

  localparam logic [CNT_W-1:0]   H_LAST  = CNT_W'(IMG_H_DISP - 1);
  localparam logic [CNT_W-1:0]   V_LAST  = CNT_W'(IMG_V_DISP - 1);
  localparam logic [PHASE_W-1:0] VB_LAST = PHASE_W'(V_BACK - 1);
  localparam logic [PHASE_W-1:0] HB_LAST = PHASE_W'(H_BLANK - 1);
  localparam logic [PHASE_W-1:0] VF_LAST = PHASE_W'(V_FRONT - 1);
  localparam logic [PHASE_W-1:0] VS_LAST = PHASE_W'(V_SYNC_LOW - 1);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;
  logic               stop_q, stop_d;
  logic               cont_q, cont_d;
  pattern_e           pat_q, pat_d;

  logic               vsync_q, href_q, fdone_q;
  logic [PIX_W-1:0]   gray_q;

  logic               pre_href, pre_vsync;
  logic [PIX_W-1:0]   mux_gray;

  assign pre_href  = (state_q == ST_ACTIVE);
  assign pre_vsync = (state_q == ST_VBACK) || (state_q == ST_ACTIVE) ||
                     (state_q == ST_HBLANK) || (state_q == ST_VFRONT);

  img_pattern_mux u_mux (
    .hcnt_i        (hcnt_q[PIX_W-1:0]),
    .vcnt_i        (vcnt_q[PIX_W-1:0]),
    .pattern_i     (pat_q),
    .src_rd_data_i (src_rd_data),
    .gray_o        (mux_gray)
  );

  // Next-state, counters, stop latch and per-frame configuration.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    stop_d  = stop_q;
    cont_d  = cont_q;
    pat_d   = pat_q;

    if (state_q != ST_IDLE && stop) stop_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d = ST_VBACK;
          pat_d   = pattern_e'(pattern_sel);
          cont_d  = continuous;
          stop_d  = stop;  // start+stop together runs exactly one frame
        end
      end
      ST_VBACK: if (phase_q == VB_LAST) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          if (vcnt_q == V_LAST) begin
            vcnt_d  = '0;
            state_d = ST_VFRONT;
          end else begin
            vcnt_d  = vcnt_q + 1'b1;
            state_d = ST_HBLANK;
          end
        end
      end
      ST_HBLANK: if (phase_q == HB_LAST) state_d = ST_ACTIVE;
      ST_VFRONT: if (phase_q == VF_LAST) state_d = ST_VSLOW;
      ST_VSLOW: begin
        if (phase_q == VS_LAST) begin
          if (cont_q && !stop_d) begin
            state_d = ST_VBACK;
            pat_d   = pattern_e'(pattern_sel);
            cont_d  = continuous;
          end else begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) phase_d = '0;
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      stop_q  <= 1'b0;
      cont_q  <= 1'b0;
      pat_q   <= PAT_EXT;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      gray_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      stop_q  <= stop_d;
      cont_q  <= cont_d;
      pat_q   <= pat_d;
      vsync_q <= pre_vsync;
      href_q  <= pre_href;
      gray_q  <= pre_href ? mux_gray : '0;
      fdone_q <= vsync_q & ~pre_vsync;
    end
  end

  // External pixels arrive one cycle after the read, already aligned with
  // href, so they bypass the gray register.
  assign out_img_gray  = (pat_q == PAT_EXT) ? (href_q ? src_rd_data : '0) : gray_q;
  assign src_rd_en     = pre_href && (pat_q == PAT_EXT);
  assign out_img_vsync = vsync_q;
  assign out_img_href  = href_q;
  assign frame_done    = fdone_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule
